// File: rtl/tff_counter_bank.sv
// Bank of WIDTH synchronous T flip-flops: per-bit toggle or chained up/down counter,
// with parallel load, wrap/saturate boundary handling, terminal-count pulse and sticky overflow.
module tff_counter_bank #(
  parameter int unsigned       WIDTH     = 4,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  parameter bit                SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  typedef enum logic [1:0] {
    MODE_TOGGLE = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  mode_e            mode_s;
  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] tog;
  logic             boundary;
  logic             run;

  assign mode_s = mode_e'(mode);

  always_comb begin
    tog      = '0;
    boundary = 1'b0;
    run      = 1'b1;
    case (mode_s)
      MODE_TOGGLE: tog = t;
      MODE_UP: begin
        // Bit i toggles when every lower bit is one (ripple carry of the T chain).
        for (int unsigned i = 0; i < WIDTH; i++) begin
          tog[i] = run;
          run    = run & q_q[i];
        end
        boundary = &q_q;
      end
      MODE_DOWN: begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
          tog[i] = run;
          run    = run & ~q_q[i];
        end
        boundary = ~|q_q;
      end
      default: ;
    endcase

    if (!en) begin
      tog      = '0;
      boundary = 1'b0;
    end
    if (SATURATE && boundary) tog = '0;

    q_d   = q_q ^ tog;
    tc_d  = boundary;
    ovf_d = boundary | (ovf_q & ~clr_ovf);

    // Load suppresses any boundary event that would have occurred this edge.
    if (load) begin
      q_d   = load_val;
      tc_d  = 1'b0;
      ovf_d = ovf_q & ~clr_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q   <= RESET_VAL;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign q   = q_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;

endmodule
